// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and state encoding for the four-way round-robin line arbiter.
package mux4_rr_arbiter_pkg;
  localparam int NUM_REQ          = 4;
  localparam int SEL_W            = 2;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/mux4.sv
// Plain 4:1 single-bit multiplexer used as the shared data path.
module mux4 (
  input  logic [1:0] select,
  input  logic       input_0,
  input  logic       input_1,
  input  logic       input_2,
  input  logic       input_3,
  output logic       out
);
  always_comb begin
    case (select)
      2'd0:    out = input_0;
      2'd1:    out = input_1;
      2'd2:    out = input_2;
      default: out = input_3;
    endcase
  end
endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set mask bit after ptr_i, ptr_i itself last.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   winner_o,
  output logic               found_o
);
  logic [SEL_W-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest hit overrides.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr_i + SEL_W'(k);
      if (mask_i[idx]) begin
        winner_o = idx;
        found_o  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four sources a shared serial line, with a
// bounded tenure so a persistent requester cannot starve the others.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               valid,
  output logic               data_out
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   pick_win;
  logic               pick_found;
  logic               others_pending;
  logic               mux_out;

  // In BUSY the owner is masked out, so release and preempt share one search.
  assign pick_mask      = (state_q == ST_IDLE) ? req : (req & ~grant_q);
  assign pick_ptr       = (state_q == ST_IDLE) ? ptr_q : sel_q;
  assign others_pending = |(req & ~grant_q);

  rr_pick4 u_pick (
    .mask_i   (pick_mask),
    .ptr_i    (pick_ptr),
    .winner_o (pick_win),
    .found_o  (pick_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_BUSY;
          grant_d = NUM_REQ'(1) << pick_win;
          sel_d   = pick_win;
          ptr_d   = pick_win;
          hold_d  = '0;
        end
      end
      default: begin
        if (!req[sel_q]) begin
          if (pick_found) begin
            grant_d = NUM_REQ'(1) << pick_win;
            sel_d   = pick_win;
            ptr_d   = pick_win;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (others_pending && (hold_q == HOLD_LAST)) begin
          grant_d = NUM_REQ'(1) << pick_win;
          sel_d   = pick_win;
          ptr_d   = pick_win;
          hold_d  = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
    endcase
  end

  mux4 u_mux (
    .select  (sel_q),
    .input_0 (data_in[0]),
    .input_1 (data_in[1]),
    .input_2 (data_in[2]),
    .input_3 (data_in[3]),
    .out     (mux_out)
  );

  always_comb begin
    valid    = (state_q == ST_BUSY);
    grant    = grant_q;
    select   = sel_q;
    data_out = mux_out & valid;
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an owner/tenure reference model.
module tb_mux4_rr_arbiter;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] req1 = '0;
  logic [3:0] data_in = '0;
  logic [3:0] grant, grant1;
  logic [1:0] select, select1;
  logic       valid, valid1, data_out, data_out1;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .data_in(data_in),
    .grant(grant), .select(select), .valid(valid), .data_out(data_out)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .data_in(data_in),
    .grant(grant1), .select(select1), .valid(valid1), .data_out(data_out1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: who owns the line, how long they have held it, where the search starts.
  int m_owner, m_held, m_ptr, m_sel;

  function automatic int pick(logic [3:0] m, int p);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_held = 0; m_ptr = 3; m_sel = 0;
  endfunction

  function automatic void model_take(int w);
    m_owner = w; m_sel = w; m_ptr = w; m_held = 1;
  endfunction

  function automatic void model_step(logic [3:0] r);
    int w;
    logic [3:0] rest;
    if (m_owner < 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) model_take(w);
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        w = pick(rest, m_owner);
        if (w >= 0) model_take(w);
        else m_owner = -1;
      end else if (rest != 4'b0 && m_held >= MAX_HOLD) begin
        model_take(pick(rest, m_owner));
      end else begin
        m_held++;
      end
    end
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    req1 = '0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic cycle(logic [3:0] r, logic [3:0] d);
    @(negedge clk);
    req = r;
    data_in = d;
    model_step(r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    logic exp_dout;
    exp_dout = (m_owner >= 0) ? data_in[m_sel] : 1'b0;
    check({tag, ".grant"}, 32'(grant), 32'(m_grant()));
    check({tag, ".select"}, 32'(select), 32'(m_sel));
    check({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
    check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] g;
    logic [1:0] sel;
    logic       v;
    logic       dout;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [3:0] r, d, exp_g;
    int owner_idx;

    vecs[0]  = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[6]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[9]  = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[10] = '{4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[12] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};

    data_in = 4'b1111;
    do_reset();
    #1;
    check("reset.grant", 32'(grant), 32'h0);
    check("reset.select", 32'(select), 32'h0);
    check("reset.valid", 32'(valid), 32'h0);
    check("reset.data_out", 32'(data_out), 32'h0);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].req, vecs[i].din);
      $display("vec %0d: req=%b din=%b -> grant=%b sel=%0d valid=%b dout=%b",
               i, vecs[i].req, vecs[i].din, grant, select, valid, data_out);
      check($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].g));
      check($sformatf("vec%0d.select", i), 32'(select), 32'(vecs[i].sel));
      check($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].v));
      check($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].dout));
    end

    // All four requesting: each source owns the line for exactly MAX_HOLD cycles in turn.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      d = 4'($urandom);
      cycle(4'b1111, d);
      owner_idx = (c / MAX_HOLD) % 4;
      exp_g = 4'b0001 << owner_idx;
      $display("rotate %0d: grant=%b sel=%0d dout=%b", c, grant, select, data_out);
      check($sformatf("rotate%0d.grant", c), 32'(grant), 32'(exp_g));
      check($sformatf("rotate%0d.data_out", c), 32'(data_out), 32'(d[owner_idx]));
    end

    // Lone holder saturates, then a newcomer preempts on the very next edge.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0001, 4'b0000);
      check($sformatf("solo%0d.grant", c), 32'(grant), 32'h1);
    end
    cycle(4'b0101, 4'b0100);
    $display("saturated preempt: grant=%b sel=%0d", grant, select);
    check("sat_preempt.grant", 32'(grant), 32'h4);
    check("sat_preempt.select", 32'(select), 32'h2);
    check("sat_preempt.data_out", 32'(data_out), 32'h1);

    // MAX_HOLD=1 instance alternates every cycle under contention.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req1 = 4'b0011;
      @(posedge clk);
      #1;
      $display("hold1 %0d: grant=%b", c, grant1);
      check($sformatf("hold1_%0d.grant", c), 32'(grant1), (c % 2 == 0) ? 32'h1 : 32'h2);
    end
    req1 = '0;

    // Reset mid-tenure clears outputs without a clock edge; search restarts at source 0.
    do_reset();
    cycle(4'b0010, 4'b1111);
    check("pre_reset.grant", 32'(grant), 32'h2);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    $display("async reset: grant=%b valid=%b dout=%b", grant, valid, data_out);
    check("async_reset.grant", 32'(grant), 32'h0);
    check("async_reset.valid", 32'(valid), 32'h0);
    check("async_reset.data_out", 32'(data_out), 32'h0);
    req = 4'b1010;
    @(negedge clk);
    reset_n = 1'b1;
    model_step(4'b1010);
    @(posedge clk);
    #1;
    $display("post reset: grant=%b sel=%0d", grant, select);
    check("post_reset.grant", 32'(grant), 32'h2);
    check("post_reset.select", 32'(select), 32'h1);

    // Randomized traffic, requests often held to build long tenures.
    do_reset();
    r = '0;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      d = 4'($urandom);
      cycle(r, d);
      $display("rand %0d: req=%b din=%b -> grant=%b sel=%0d valid=%b dout=%b",
               c, r, d, grant, select, valid, data_out);
      check_model($sformatf("rand%0d", c));
      check($sformatf("rand%0d.onehot", c), 32'($onehot0(grant)), 32'h1);
      check($sformatf("rand%0d.grant_sel", c), 32'(grant[select]), 32'(valid));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
